// File: rtl/adc_chirp_framer.sv
// Frames gated ADC samples into AXI-Stream chirp packets (tuser = CPI start, tlast = chirp end) through a FIFO.
// Build macro ADC_TEST_PATTERN_EN replaces each captured sample with {chirp_cnt, scnt}.
module adc_chirp_framer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W      = 16
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              enable_i,
  input  logic              cpib_i,
  input  logic              cpie_i,
  input  logic              sample_gate_i,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              adc_valid_i,
  input  logic [LEN_W-1:0]  expected_len_i,
  input  logic              clear_err_i,
  output logic [DATA_W-1:0] m_axis_tdata_o,
  output logic              m_axis_tvalid_o,
  input  logic              m_axis_tready_i,
  output logic              m_axis_tlast_o,
  output logic              m_axis_tuser_o,
  output logic [7:0]        chirp_cnt_o,
  output logic              frame_done_o,
  output logic              overflow_err_o,
  output logic              len_err_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;

  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, CLOSE, DISCARD} state_e;
  state_e state_q, state_d;

  logic [1:0]        cpib_q, cpie_q, gate_q;
  logic              cpib_rise, cpie_rise, gate_rise, gate_fall;
  logic [LEN_W-1:0]  len_q, len_d, scnt_q, scnt_d;
  logic [7:0]        chirp_cnt_q, chirp_cnt_d;
  logic              sof_pend_q, sof_pend_d;
  logic [DATA_W-1:0] hold_q, hold_d, sample;
  logic              ovf_q, ovf_d, len_err_q, len_err_d, set_ovf, set_len;
  logic              frame_done_q;
  logic              try_wr, wr_en;
  logic [EW-1:0]     wr_word, rd_word;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [AW:0]       wptr_q, rptr_q, rptr_d;
  logic              full, fire;
  logic              tvalid_q, tvalid_d, tlast_q, tuser_q;
  logic [DATA_W-1:0] tdata_q;

  // Edges come from the second register stage: one cycle of edge latency
  assign cpib_rise = cpib_q[0] & ~cpib_q[1];
  assign cpie_rise = cpie_q[0] & ~cpie_q[1];
  assign gate_rise = gate_q[0] & ~gate_q[1];
  assign gate_fall = ~gate_q[0] & gate_q[1];

`ifdef ADC_TEST_PATTERN_EN
  assign sample = DATA_W'({chirp_cnt_q, scnt_q[7:0]});
`else
  assign sample = adc_data_i;
`endif

  assign full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    scnt_d      = scnt_q;
    chirp_cnt_d = chirp_cnt_q;
    sof_pend_d  = sof_pend_q;
    hold_d      = hold_q;
    try_wr      = 1'b0;
    wr_en       = 1'b0;
    wr_word     = '0;
    set_ovf     = 1'b0;
    set_len     = 1'b0;
    if (cpib_rise) begin
      if (enable_i) begin
        len_d       = expected_len_i;
        chirp_cnt_d = '0;
        sof_pend_d  = 1'b1;
        state_d     = ARMED;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        ARMED: begin
          if (gate_rise) begin
            scnt_d  = '0;
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (gate_fall || cpie_rise) begin
            state_d = CLOSE;
          end else if (gate_q[0] && adc_valid_i && (scnt_q < len_q)) begin
            hold_d = sample;
            scnt_d = scnt_q + LEN_W'(1);
            if (scnt_q != '0) begin
              try_wr  = 1'b1;
              wr_word = {sof_pend_q, 1'b0, hold_q};
            end
          end
        end
        CLOSE: begin
          state_d     = ARMED;
          chirp_cnt_d = (chirp_cnt_q == 8'hFF) ? chirp_cnt_q : chirp_cnt_q + 8'd1;
          if (scnt_q == '0) begin
            set_len = 1'b1;
          end else begin
            try_wr  = 1'b1;
            wr_word = {sof_pend_q, 1'b1, hold_q};
            if (scnt_q < len_q) set_len = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // A write into a full FIFO abandons the rest of the CPI
    if (try_wr) begin
      if (full) begin
        set_ovf     = 1'b1;
        state_d     = DISCARD;
        chirp_cnt_d = chirp_cnt_q;
      end else begin
        wr_en      = 1'b1;
        sof_pend_d = 1'b0;
      end
    end
  end

  assign ovf_d     = set_ovf | (ovf_q & ~clear_err_i);
  assign len_err_d = set_len | (len_err_q & ~clear_err_i);

  // Output slice presents the entry at rptr; rptr advances only on a transfer
  assign fire     = tvalid_q & m_axis_tready_i;
  assign rptr_d   = rptr_q + (AW+1)'(fire);
  assign rd_word  = mem_q[rptr_d[AW-1:0]];
  assign tvalid_d = (wptr_q != rptr_d);

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cpib_q       <= '0;
      cpie_q       <= '0;
      gate_q       <= '0;
      len_q        <= '0;
      scnt_q       <= '0;
      chirp_cnt_q  <= '0;
      sof_pend_q   <= 1'b0;
      ovf_q        <= 1'b0;
      len_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpib_q       <= {cpib_q[0], cpib_i};
      cpie_q       <= {cpie_q[0], cpie_i};
      gate_q       <= {gate_q[0], sample_gate_i};
      len_q        <= len_d;
      scnt_q       <= scnt_d;
      chirp_cnt_q  <= chirp_cnt_d;
      sof_pend_q   <= sof_pend_d;
      ovf_q        <= ovf_d;
      len_err_q    <= len_err_d;
      frame_done_q <= cpie_rise;
      wptr_q       <= wptr_q + (AW+1)'(wr_en);
      rptr_q       <= rptr_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= rd_word[DATA_W-1:0];
      tlast_q      <= rd_word[DATA_W];
      tuser_q      <= rd_word[DATA_W+1];
    end
  end

  always_ff @(posedge sys_clk) begin
    hold_q <= hold_d;
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= wr_word;
  end

  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tlast_o  = tlast_q;
  assign m_axis_tuser_o  = tuser_q;
  assign chirp_cnt_o     = chirp_cnt_q;
  assign frame_done_o    = frame_done_q;
  assign overflow_err_o  = ovf_q;
  assign len_err_o       = len_err_q;
endmodule

// File: tb/tb_adc_chirp_framer.sv
// Randomized bench for adc_chirp_framer: a packet-level model predicts the stream, sticky flags and chirp count.
`timescale 1ns/1ps
module tb_adc_chirp_framer;
  localparam int DATA_W = 16;
  localparam int FIFO_DEPTH = 16;
  localparam int LEN_W = 16;

  logic sys_clk = 1'b0, rstn = 1'b0;
  logic enable = 1'b0, cpib = 1'b0, cpie = 1'b0, gate = 1'b0, adc_valid = 1'b0;
  logic clear_err = 1'b0, tready = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic [LEN_W-1:0] expected_len = '0;
  logic [DATA_W-1:0] tdata;
  logic tvalid, tlast, tuser, frame_done, ovf, len_err;
  logic [7:0] chirp_cnt;

  always #5 sys_clk = ~sys_clk;

  adc_chirp_framer #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
    .sys_clk(sys_clk), .rstn(rstn), .enable_i(enable), .cpib_i(cpib), .cpie_i(cpie),
    .sample_gate_i(gate), .adc_data_i(adc_data), .adc_valid_i(adc_valid),
    .expected_len_i(expected_len), .clear_err_i(clear_err),
    .m_axis_tdata_o(tdata), .m_axis_tvalid_o(tvalid), .m_axis_tready_i(tready),
    .m_axis_tlast_o(tlast), .m_axis_tuser_o(tuser), .chirp_cnt_o(chirp_cnt),
    .frame_done_o(frame_done), .overflow_err_o(ovf), .len_err_o(len_err));

  typedef struct packed {logic sof; logic last; logic [DATA_W-1:0] data;} word_t;

  int vectors = 0, miscompares = 0;
  word_t exp_q[$];
  logic [DATA_W-1:0] last_chirp_data[$];
  bit cpi_en, cpi_sof, discarding, exp_len_err, exp_ovf, chk_en;
  int m_chirp, m_len, cap_left = -1, tready_mode = 0;
  int out_cnt, last_cnt, user_cnt, fd_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  always @(posedge sys_clk) begin
    #1;
    case (tready_mode)
      0: tready = 1'b1;
      1: tready = 1'b0;
      2: tready = ~tready;
      default: tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare process: every transfer against the model queue, plus hold stability under backpressure
  word_t e, prev_w;
  bit hold_prev = 0;
  always @(negedge sys_clk) begin
    if (rstn && frame_done) fd_cnt++;
    if (!rstn || !chk_en) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        vectors++;
        if (!tvalid || {tuser, tlast, tdata} !== prev_w) begin
          miscompares++;
          $display("FAIL hold_stable: got v=%0d %h, expected v=1 %h", tvalid, {tuser, tlast, tdata}, prev_w);
        end
      end
      if (tvalid && tready) begin
        vectors++;
        out_cnt++;
        if (tlast) last_cnt++;
        if (tuser) user_cnt++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word: got %h, expected no word", {tuser, tlast, tdata});
        end else begin
          e = exp_q.pop_front();
          if ({tuser, tlast, tdata} !== e) begin
            miscompares++;
            $display("FAIL stream_word: got sof=%0d last=%0d data=%h, expected sof=%0d last=%0d data=%h",
                     tuser, tlast, tdata, e.sof, e.last, e.data);
          end
        end
      end
      hold_prev = tvalid && !tready;
      prev_w = {tuser, tlast, tdata};
    end
  end

  function automatic void push_word(input logic [DATA_W-1:0] d, input bit last);
    word_t w;
    if (discarding) return;
    if (cap_left == 0) begin
      discarding = 1;
      exp_ovf = 1;
      return;
    end
    if (cap_left > 0) cap_left--;
    w.sof = cpi_sof;
    w.last = last;
    w.data = d;
    cpi_sof = 0;
    exp_q.push_back(w);
  endfunction

  function automatic logic [DATA_W-1:0] sample_value(input int idx, input logic [DATA_W-1:0] raw);
`ifdef ADC_TEST_PATTERN_EN
    return DATA_W'({m_chirp[7:0], idx[7:0]});
`else
    if (idx < 0) return '0;
    return raw;
`endif
  endfunction

  task automatic reset_counts();
    out_cnt = 0; last_cnt = 0; user_cnt = 0;
  endtask

  task automatic cpi_begin(input int len, input bit en);
    expected_len = len[LEN_W-1:0];
    enable = en;
    cpib = 1; repeat (3) tick();
    cpib = 0; repeat (2) tick();
    cpi_en = en;
    if (en) begin
      m_len = len; m_chirp = 0; cpi_sof = 1; discarding = 0;
    end
  endtask

  task automatic chirp(input int n);
    int ncap;
    logic [DATA_W-1:0] v;
    ncap = (n < m_len) ? n : m_len;
    last_chirp_data.delete();
    gate = 1; repeat (4) tick();
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      adc_valid = 0; adc_data = DATA_W'($urandom);
      repeat (gap) tick();
      adc_data = DATA_W'($urandom); adc_valid = 1;
      if (cpi_en && i < ncap) begin
        v = sample_value(i, adc_data);
        last_chirp_data.push_back(v);
        push_word(v, i == ncap - 1);
      end
      tick();
    end
    adc_valid = 0; repeat (3) tick();
    gate = 0; repeat (5) tick();
    if (cpi_en && !discarding) begin
      if (n < m_len) exp_len_err = 1;
      if (m_chirp < 255) m_chirp++;
    end
  endtask

  task automatic cpi_end();
    int f0;
    f0 = fd_cnt;
    cpie = 1; repeat (3) tick();
    cpie = 0; repeat (3) tick();
    chk("frame_done_pulses", fd_cnt - f0, 1);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 3000) begin tick(); b++; end
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) tick();
    chk("idle_tvalid", tvalid, 0);
  endtask

  task automatic pulse_clear();
    clear_err = 1; tick(); clear_err = 0; tick();
    exp_len_err = 0; exp_ovf = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_en = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_tvalid", tvalid, 0); chk("rst_tdata", tdata, 0); chk("rst_tlast", tlast, 0);
    chk("rst_tuser", tuser, 0); chk("rst_chirp_cnt", chirp_cnt, 0); chk("rst_frame_done", frame_done, 0);
    chk("rst_ovf", ovf, 0); chk("rst_len_err", len_err, 0);
    rstn = 1; tick(); tick(); chk_en = 1;

    // Nominal frame
    tready_mode = 0; reset_counts();
    cpi_begin(8, 1);
    repeat (4) chirp(8);
    cpi_end(); drain();
    chk("nom_words", out_cnt, 32); chk("nom_tlast", last_cnt, 4); chk("nom_tuser", user_cnt, 1);
    chk("nom_chirp_cnt", chirp_cnt, 4); chk("nom_chirp_model", chirp_cnt, m_chirp);
    chk("nom_len_err", len_err, 0);

    // Short chirp
    reset_counts(); cpi_begin(8, 1); chirp(5); drain();
    chk("short_words", out_cnt, 5); chk("short_tlast", last_cnt, 1);
    chk("short_len_err", len_err, 1); chk("short_len_err_model", len_err, exp_len_err);
    cpi_end(); pulse_clear();
    chk("clear_len_err", len_err, 0);

    // Long chirp (truncation)
    reset_counts(); cpi_begin(4, 1); chirp(10); drain();
    chk("long_words", out_cnt, 4); chk("long_len_err", len_err, 0);
    cpi_end();

    // Overflow under full backpressure
    tready_mode = 1; reset_counts(); cap_left = 16;
    cpi_begin(20, 1); chirp(20);
    chk("ovf_flag", ovf, 1); chk("ovf_model", ovf, exp_ovf); chk("ovf_tvalid", tvalid, 1);
    chk("ovf_chirp_cnt", chirp_cnt, 0);
    cpi_end(); tready_mode = 0; drain();
    chk("ovf_words", out_cnt, 16); chk("ovf_tlast", last_cnt, 0);
    cap_left = -1; reset_counts();
    cpi_begin(8, 1); chirp(8); drain();
    chk("post_ovf_words", out_cnt, 8); chk("post_ovf_tuser", user_cnt, 1);
    cpi_end(); pulse_clear();
    chk("clear_ovf", ovf, 0);

    // Toggling tready
    tready_mode = 2; reset_counts();
    cpi_begin(16, 1); chirp(16); drain();
    chk("tog_words", out_cnt, 16); chk("tog_tlast", last_cnt, 1);
    cpi_end();

    // Disabled CPI: nothing captured, count held
    tready_mode = 0; reset_counts();
    cpi_begin(8, 0); chirp(5); repeat (6) tick();
    chk("dis_words", out_cnt, 0); chk("dis_chirp_cnt", chirp_cnt, m_chirp);
    cpi_end();

    // Random CPIs
    tready_mode = 3;
    for (int c = 0; c < 6; c++) begin
      int nch;
      nch = $urandom_range(1, 4);
      cpi_begin($urandom_range(1, 12), 1);
      for (int k = 0; k < nch; k++) begin
        chirp($urandom_range(0, 14)); drain();
        chk("rnd_chirp_cnt", chirp_cnt, m_chirp);
        chk("rnd_len_err", len_err, exp_len_err);
        chk("rnd_ovf", ovf, exp_ovf);
        if ($urandom_range(0, 1) == 1) begin
          pulse_clear(); chk("rnd_clear", len_err, 0);
        end
      end
      cpi_end();
    end

    // Pattern check on chirp 2, then reset mid-chirp
    tready_mode = 0;
    cpi_begin(8, 1); chirp(2); chirp(2); chirp(3);
`ifdef ADC_TEST_PATTERN_EN
    chk("pat_w0", last_chirp_data[0], 16'h0200);
    chk("pat_w1", last_chirp_data[1], 16'h0201);
    chk("pat_w2", last_chirp_data[2], 16'h0202);
`endif
    drain();
    chk("pre_rst_chirp_cnt", chirp_cnt, 3);
    tready_mode = 1; tick();
    gate = 1; repeat (4) tick();
    for (int i = 0; i < 3; i++) begin adc_data = DATA_W'($urandom); adc_valid = 1; tick(); end
    adc_valid = 0; repeat (3) tick();
    chk("pre_rst_tvalid", tvalid, 1); chk("pre_rst_len_err", len_err, 1);
    chk_en = 0; rstn = 0; #1;
    chk("mid_rst_tvalid", tvalid, 0); chk("mid_rst_chirp_cnt", chirp_cnt, 0);
    chk("mid_rst_len_err", len_err, 0); chk("mid_rst_ovf", ovf, 0);
    tick(); gate = 0;
    chk("mid_rst_tvalid_next", tvalid, 0);
    exp_q.delete(); exp_len_err = 0; exp_ovf = 0; m_chirp = 0;
    rstn = 1; tready_mode = 0; tick(); tick(); chk_en = 1;
    reset_counts(); cpi_begin(6, 1); chirp(6); drain();
    chk("post_rst_words", out_cnt, 6); chk("post_rst_tuser", user_cnt, 1);
    cpi_end();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
